vga_fetch_ctrl: RTL and testbench

//  Framebuffer read scheduler feeding the VGA timing generator. Issues Wishbone

---
 rtl/vga_fetch_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_vga_fetch_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_fetch_ctrl : Wishbone burst reader keeping a show-ahead pixel FIFO full |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module vga_fetch_ctrl #(
   parameter int          HDISP      = 800,
   parameter int          VDISP      = 480,
   parameter logic [31:0] BASE_ADDR  = 32'h0,
   parameter int          BURST      = 16,
   parameter int          FIFO_DEPTH = 64
) (
   input  logic        pixel_clk,
   input  logic        pixel_rst,
   input  logic        frame_start,
   input  logic        pix_rd,
   output logic [23:0] pix_data,
   output logic        pix_valid,
   output logic        underflow,
   output logic        wb_cyc,
   output logic        wb_stb,
   output logic [31:0] wb_adr,
   input  logic        wb_ack,
   input  logic [31:0] wb_dat_i
);

   localparam int TOTAL = HDISP * VDISP;
   localparam int CNT_W = $clog2(TOTAL + 1);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int BT_W  = $clog2(BURST + 1);

   localparam logic [CNT_W-1:0] TOTAL_C   = CNT_W'(TOTAL);
   localparam logic [LVL_W-1:0] DEPTH_C   = LVL_W'(FIFO_DEPTH);
   localparam logic [LVL_W-1:0] BURST_C   = LVL_W'(BURST);
   localparam logic [BT_W-1:0]  BEAT_LAST = BT_W'(BURST - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_BURST = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              cyc_q, cyc_d;
   logic [31:0]       adr_q, adr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [BT_W-1:0]   beat_q, beat_d;
   logic              pend_q, pend_d;
   logic              uf_q, uf_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [23:0]       mem_q [FIFO_DEPTH];

   logic push, pop, flush, space_ok;
   logic unused_dat;

   assign unused_dat = ^wb_dat_i[31:24];
   assign space_ok   = (DEPTH_C - level_q) >= BURST_C;

   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      adr_d   = adr_q;
      cnt_d   = cnt_q;
      beat_d  = beat_q;
      pend_d  = pend_q;
      flush   = 1'b0;
      push    = 1'b0;
      case (state_q)
         S_IDLE, S_FILL: begin
            // A restart always finds an empty FIFO, so FILL is skipped and the
            // burst goes out on the very next cycle.
            if (frame_start) begin
               flush   = 1'b1;
               adr_d   = BASE_ADDR;
               cnt_d   = '0;
               beat_d  = '0;
               state_d = S_BURST;
               cyc_d   = 1'b1;
            end else if (state_q == S_FILL) begin
               if (cnt_q == TOTAL_C) begin
                  state_d = S_IDLE;
               end else if (space_ok) begin
                  state_d = S_BURST;
                  cyc_d   = 1'b1;
               end
            end
         end
         S_BURST: begin
            if (frame_start) pend_d = 1'b1;
            if (wb_ack) begin
               push   = 1'b1;
               adr_d  = adr_q + 32'd4;
               cnt_d  = cnt_q + 1'b1;
               beat_d = beat_q + 1'b1;
               if (beat_q == BEAT_LAST) begin
                  beat_d  = '0;
                  cyc_d   = 1'b0;
                  state_d = S_FILL;
                  if (pend_q || frame_start) begin
                     flush  = 1'b1;
                     pend_d = 1'b0;
                     adr_d  = BASE_ADDR;
                     cnt_d  = '0;
                  end
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            cyc_d   = 1'b0;
         end
      endcase
   end

   always_comb begin
      pop      = pix_rd && (level_q != '0) && !flush;
      uf_d     = uf_q;
      level_d  = level_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (frame_start)
         uf_d = 1'b0;
      else if (pix_rd && (level_q == '0))
         uf_d = 1'b1;
      if (flush) begin
         level_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
         endcase
      end
   end

   always_ff @(posedge pixel_clk or negedge pixel_rst) begin
      if (!pixel_rst) begin
         state_q  <= S_IDLE;
         cyc_q    <= 1'b0;
         adr_q    <= BASE_ADDR;
         cnt_q    <= '0;
         beat_q   <= '0;
         pend_q   <= 1'b0;
         uf_q     <= 1'b0;
         level_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         cyc_q    <= cyc_d;
         adr_q    <= adr_d;
         cnt_q    <= cnt_d;
         beat_q   <= beat_d;
         pend_q   <= pend_d;
         uf_q     <= uf_d;
         level_q  <= level_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
      end
   end

   // Storage needs no reset: level and pointers gate everything visible.
   always_ff @(posedge pixel_clk) begin
      if (push) mem_q[wr_ptr_q] <= wb_dat_i[23:0];
   end

   assign pix_valid = (level_q != '0);
   assign pix_data  = pix_valid ? mem_q[rd_ptr_q] : 24'h0;
   assign underflow = uf_q;
   assign wb_cyc    = cyc_q;
   assign wb_stb    = cyc_q;
   assign wb_adr    = adr_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vga_fetch_ctrl : directed vectors and sequences for vga_fetch_ctrl      |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_vga_fetch_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n = 1'b0;
   logic        fs = 1'b0, rd = 1'b0, ack = 1'b0;
   logic [31:0] dat = 32'h0;
   logic [23:0] pdata;
   logic        pvalid, uf, cyc, stb;
   logic [31:0] adr;

   logic        fs1 = 1'b0, rd1 = 1'b0, ack1 = 1'b0;
   logic [31:0] dat1 = 32'h0;
   logic [23:0] pdata1;
   logic        pvalid1, uf1, cyc1, stb1;
   logic [31:0] adr1;

   vga_fetch_ctrl u_dut (
      .pixel_clk(clk), .pixel_rst(rst_n), .frame_start(fs), .pix_rd(rd),
      .pix_data(pdata), .pix_valid(pvalid), .underflow(uf),
      .wb_cyc(cyc), .wb_stb(stb), .wb_adr(adr), .wb_ack(ack), .wb_dat_i(dat)
   );

   vga_fetch_ctrl #(.HDISP(8), .VDISP(4), .BASE_ADDR(32'h0), .BURST(4), .FIFO_DEPTH(64)) u_small (
      .pixel_clk(clk), .pixel_rst(rst_n), .frame_start(fs1), .pix_rd(rd1),
      .pix_data(pdata1), .pix_valid(pvalid1), .underflow(uf1),
      .wb_cyc(cyc1), .wb_stb(stb1), .wb_adr(adr1), .wb_ack(ack1), .wb_dat_i(dat1)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] dword(input int k);
      return {8'hA5, 24'h100000 + 24'(k)};
   endfunction

   // Reference FIFO contents and sticky flag
   logic [23:0] q[$];
   logic        uf_exp = 1'b0;

   task automatic tick(input logic f, input logic r, input logic a,
                       input logic [31:0] d, input logic fl);
      logic [23:0] head;
      fs = f; rd = r; ack = a; dat = d;
      if (f) uf_exp = 1'b0;
      else if (r && q.size() == 0) uf_exp = 1'b1;
      if (r && q.size() != 0) void'(q.pop_front());
      if (a) q.push_back(d[23:0]);
      if (fl) q.delete();
      @(posedge clk); #1;
      head = (q.size() != 0) ? q[0] : 24'h0;
      check("pix_valid", 32'(pvalid), 32'(q.size() != 0));
      check("pix_data", 32'(pdata), 32'(head));
      check("underflow", 32'(uf), 32'(uf_exp));
   endtask

   typedef struct {
      logic        fs, rd, ack;
      logic [31:0] dat;
      logic        cyc;
      logic [31:0] adr;
      logic        valid;
      logic [23:0] data;
   } vec_t;

   vec_t        tbl[18];
   logic [31:0] d0;
   int          nw, w, bursts;
   logic        cyc_now, a, prev;
   logic [31:0] last_adr;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      d0 = dword(0);
      tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 24'h0};
      for (int k = 1; k <= 16; k++)
         tbl[k] = '{1'b0, 1'b0, 1'b1, dword(k - 1), (k < 16), 32'(4 * k), 1'b1, d0[23:0]};
      tbl[17] = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1, d0[23:0]};

      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      check("rst_cyc", 32'(cyc), 32'h0);
      check("rst_stb", 32'(stb), 32'h0);
      check("rst_adr", adr, 32'h0);
      check("rst_valid", 32'(pvalid), 32'h0);
      check("rst_data", 32'(pdata), 32'h0);
      check("rst_underflow", 32'(uf), 32'h0);

      // First frame: start latency, first burst addresses, show-ahead data
      for (int i = 0; i < 18; i++) begin
         tick(tbl[i].fs, tbl[i].rd, tbl[i].ack, tbl[i].dat, tbl[i].fs);
         check($sformatf("tbl%0d_cyc", i), 32'(cyc), 32'(tbl[i].cyc));
         check($sformatf("tbl%0d_stb", i), 32'(stb), 32'(tbl[i].cyc));
         check($sformatf("tbl%0d_adr", i), adr, tbl[i].adr);
         check($sformatf("tbl%0d_valid", i), 32'(pvalid), 32'(tbl[i].valid));
         check($sformatf("tbl%0d_data", i), 32'(pdata), 32'(tbl[i].data));
      end

      // No pops: FIFO fills after four bursts and fetching stops
      nw = 16;
      for (int i = 0; i < 100; i++) begin
         a = cyc;
         tick(1'b0, 1'b0, a, dword(nw), 1'b0);
         if (a) nw++;
      end
      check("full_words", 32'(nw), 32'd64);
      check("full_cyc", 32'(cyc), 32'h0);
      check("full_adr", adr, 32'h100);

      for (int i = 0; i < 16; i++) tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 5 && !cyc; i++) tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      check("burst5_cyc", 32'(cyc), 32'h1);
      check("burst5_adr", adr, 32'h100);

      // Pop every cycle against a 2-wait slave until the FIFO runs dry
      w = 0;
      for (int i = 0; i < 600 && !uf_exp; i++) begin
         cyc_now = cyc;
         a = cyc_now && (w == 2);
         tick(1'b0, 1'b1, a, dword(nw), 1'b0);
         if (a) nw++;
         w = (!cyc_now || a) ? 0 : w + 1;
      end
      check("drain_underflow", 32'(uf), 32'h1);

      // frame_start on the 5th ack of a fresh burst
      for (int i = 0; i < 40 && cyc; i++) begin
         tick(1'b0, 1'b0, 1'b1, dword(nw), 1'b0);
         nw++;
      end
      for (int i = 0; i < 5 && !cyc; i++) tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      check("pend_burst_start", 32'(cyc), 32'h1);
      for (int k = 1; k <= 16; k++) begin
         tick((k == 5), 1'b0, 1'b1, dword(1000 + k), (k == 16));
         if (k == 5) check("pend_uf_clear", 32'(uf), 32'h0);
         if (k == 15) check("pend_cyc_held", 32'(cyc), 32'h1);
      end
      check("pend_flush_valid", 32'(pvalid), 32'h0);
      check("pend_cyc_drop", 32'(cyc), 32'h0);
      tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      check("restart_cyc", 32'(cyc), 32'h1);
      check("restart_adr", adr, 32'h0);

      // Asynchronous reset in the middle of a burst
      tick(1'b0, 1'b0, 1'b1, dword(2000), 1'b0);
      tick(1'b0, 1'b0, 1'b1, dword(2001), 1'b0);
      ack = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("arst_cyc", 32'(cyc), 32'h0);
      check("arst_stb", 32'(stb), 32'h0);
      check("arst_valid", 32'(pvalid), 32'h0);
      check("arst_adr", adr, 32'h0);
      check("arst_data", 32'(pdata), 32'h0);
      q.delete();
      uf_exp = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;

      // Small frame: 32 words in 4-word bursts, then idle
      fs1 = 1'b1;
      @(posedge clk); #1;
      fs1 = 1'b0;
      check("small_start_cyc", 32'(cyc1), 32'h1);
      check("small_start_adr", adr1, 32'h0);
      prev = 1'b0; bursts = 0; last_adr = 32'hFFFF_FFFF;
      for (int i = 0; i < 150; i++) begin
         if (cyc1 && !prev) begin
            bursts++;
            last_adr = adr1;
         end
         prev = cyc1;
         ack1 = cyc1;
         dat1 = dword(i);
         @(posedge clk); #1;
      end
      ack1 = 1'b0;
      check("small_bursts", 32'(bursts), 32'd8);
      check("small_last_adr", last_adr, 32'h70);
      check("small_idle_cyc", 32'(cyc1), 32'h0);
      check("small_valid", 32'(pvalid1), 32'h1);
      fs1 = 1'b1;
      @(posedge clk); #1;
      fs1 = 1'b0;
      check("small_again_cyc", 32'(cyc1), 32'h1);
      check("small_again_adr", adr1, 32'h0);
      check("small_again_valid", 32'(pvalid1), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
